// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution unit.
package cond_pkg;

  localparam int FLAGS_W = 4;

  // Bit positions of the flags inside an NZCV nibble.
  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

  typedef enum logic {
    WIN_IDLE   = 1'b0,
    WIN_ACTIVE = 1'b1
  } win_state_e;

endpackage

// File: rtl/cond_unit_mc_if.sv
// Execute-stage bundle between decode/ALU/hazard logic and the condition unit.
interface cond_unit_mc_if
  import cond_pkg::*;
#(
  parameter int NUM_FSETS = 2,
  parameter int IT_MAX    = 4
);
  localparam int FSET_W = (NUM_FSETS > 1) ? $clog2(NUM_FSETS) : 1;
  localparam int LEN_W  = $clog2(IT_MAX + 1);

  logic               StallE;
  logic               FlushE;
  logic [3:0]         CondE;
  logic [FSET_W-1:0]  FsetE;
  logic [1:0]         FlagWE;
  logic [FLAGS_W-1:0] AluFlags;
  logic               BranchE;
  logic               RegWriteE;
  logic               MemWriteE;
  logic               NoWriteE;
  logic               ItStartE;
  logic [3:0]         ItCondE;
  logic [LEN_W-1:0]   ItLenE;

  logic               PCSrcE;
  logic               RegWE;
  logic               MemWE;
  logic               CondExE;
  logic               ItActive;
  logic [FLAGS_W-1:0] FlagsE;

  // Pipeline side: drives the decoded controls, consumes the gated strobes.
  modport master (
    output StallE, FlushE, CondE, FsetE, FlagWE, AluFlags,
           BranchE, RegWriteE, MemWriteE, NoWriteE,
           ItStartE, ItCondE, ItLenE,
    input  PCSrcE, RegWE, MemWE, CondExE, ItActive, FlagsE
  );

  // Condition unit side.
  modport slave (
    input  StallE, FlushE, CondE, FsetE, FlagWE, AluFlags,
           BranchE, RegWriteE, MemWriteE, NoWriteE,
           ItStartE, ItCondE, ItLenE,
    output PCSrcE, RegWE, MemWE, CondExE, ItActive, FlagsE
  );

endinterface

// File: rtl/cond_eval.sv
// Combinational evaluation of a 4-bit condition code against an NZCV nibble.
module cond_eval
  import cond_pkg::*;
(
  input  cond_e              cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               pass
);

  logic n, z, c, v;

  assign n = flags[N];
  assign z = flags[Z];
  assign c = flags[C];
  assign v = flags[V];

  // Decode the condition table.
  always_comb begin
    pass = 1'b0;
    case (cond)
      EQ: pass = z;
      NE: pass = !z;
      CS: pass = c;
      CC: pass = !c;
      MI: pass = n;
      PL: pass = !n;
      VS: pass = v;
      VC: pass = !v;
      HI: pass = c && !z;
      LS: pass = !c || z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = !z && (n == v);
      LE: pass = z || (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_mc.sv
// Execute-stage conditional-execution unit: multiple NZCV flag sets,
// full 4-bit conditions, IT-style predication window, strobe gating.
module cond_unit_mc
  import cond_pkg::*;
#(
  parameter int NUM_FSETS = 2,
  parameter int IT_MAX    = 4
) (
  input  logic          clk,
  input  logic          rst,
  cond_unit_mc_if.slave bus
);

  localparam int FSET_W = (NUM_FSETS > 1) ? $clog2(NUM_FSETS) : 1;
  localparam int CNT_W  = $clog2(IT_MAX + 1);

  logic [FLAGS_W-1:0] flags_q [NUM_FSETS];
  logic [CNT_W-1:0]   it_cnt;
  cond_e              it_cond;
  win_state_e         win_state;

  logic               fset_ok;
  logic [FLAGS_W-1:0] cur_flags;
  cond_e              eff_cond;
  logic               eval_pass;
  logic               valid;
  logic               cond_ex;
  logic               pcsrc;
  logic               advance;
  logic               flag_upd;
  logic [CNT_W-1:0]   len_clamped;
  logic [CNT_W-1:0]   cnt_nxt;
  cond_e              cond_nxt;

  assign fset_ok = (32'(bus.FsetE) < 32'(NUM_FSETS));

  // Read the selected flag set; an out-of-range selector reads as zero.
  always_comb begin
    cur_flags = '0;
    for (int i = 0; i < NUM_FSETS; i++) begin
      if (fset_ok && (bus.FsetE == FSET_W'(i))) cur_flags = flags_q[i];
    end
  end

  // An open window overrides the instruction's own condition.
  assign eff_cond = (win_state == WIN_ACTIVE) ? it_cond : cond_e'(bus.CondE);

  cond_eval u_eval (
    .cond  (eff_cond),
    .flags (cur_flags),
    .pass  (eval_pass)
  );

  // The window-opening instruction itself always executes.
  assign valid   = !bus.FlushE;
  assign cond_ex = (bus.ItStartE || eval_pass) && valid;
  assign pcsrc   = cond_ex && bus.BranchE;
  assign advance = valid && !bus.StallE;
  assign flag_upd = cond_ex && !bus.StallE && fset_ok;

  assign bus.CondExE  = cond_ex;
  assign bus.PCSrcE   = pcsrc;
  assign bus.RegWE    = cond_ex && bus.RegWriteE && !bus.NoWriteE;
  assign bus.MemWE    = cond_ex && bus.MemWriteE;
  assign bus.ItActive = (win_state == WIN_ACTIVE);
  assign bus.FlagsE   = cur_flags;

  assign len_clamped = (bus.ItLenE > CNT_W'(IT_MAX)) ? CNT_W'(IT_MAX) : bus.ItLenE;

  // Next window state: taken branch kills, a start (re)loads, otherwise count down.
  always_comb begin
    cnt_nxt  = it_cnt;
    cond_nxt = it_cond;
    if (advance) begin
      if (pcsrc) begin
        cnt_nxt = '0;
      end else if (bus.ItStartE) begin
        cnt_nxt  = len_clamped;
        cond_nxt = cond_e'(bus.ItCondE);
      end else if (it_cnt != '0) begin
        cnt_nxt = it_cnt - CNT_W'(1);
      end
    end
  end

  // Window counter, window condition and IDLE/ACTIVE state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      it_cnt    <= '0;
      it_cond   <= EQ;
      win_state <= WIN_IDLE;
    end else begin
      it_cnt    <= cnt_nxt;
      it_cond   <= cond_nxt;
      win_state <= (cnt_nxt != '0) ? WIN_ACTIVE : WIN_IDLE;
    end
  end

  // Flag sets with independent N/Z and C/V half enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FSETS; i++) flags_q[i] <= '0;
    end else if (flag_upd) begin
      for (int i = 0; i < NUM_FSETS; i++) begin
        if (bus.FsetE == FSET_W'(i)) begin
          if (bus.FlagWE[1]) flags_q[i][N:Z] <= bus.AluFlags[N:Z];
          if (bus.FlagWE[0]) flags_q[i][C:V] <= bus.AluFlags[C:V];
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_unit_mc.sv
// Self-checking bench for cond_unit_mc: directed steps followed by random
// instructions, compared against a behavioural model of the unit.
module tb_cond_unit_mc;

  localparam int NF   = 3;
  localparam int ITM  = 4;

  logic clk;
  logic rst;

  cond_unit_mc_if #(.NUM_FSETS(NF), .IT_MAX(ITM)) bus ();

  cond_unit_mc #(.NUM_FSETS(NF), .IT_MAX(ITM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Behavioural model state
  logic [3:0] m_flags [NF];
  int         m_cnt;
  logic [3:0] m_itc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
    bit fn, fz, fc, fv;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    case (c)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fn;
      4'h5: return !fn;
      4'h6: return fv;
      4'h7: return !fv;
      4'h8: return fc && !fz;
      4'h9: return !fc || fz;
      4'hA: return fn == fv;
      4'hB: return fn != fv;
      4'hC: return !fz && (fn == fv);
      4'hD: return fz || (fn != fv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags();
    if (int'(bus.FsetE) < NF) return m_flags[bus.FsetE];
    return 4'h0;
  endfunction

  // Expected strobes for the current inputs: {PCSrc, RegWE, MemWE, CondEx}
  function automatic logic [3:0] ref_strobes();
    logic [3:0] eff;
    bit ok;
    eff = (m_cnt != 0) ? m_itc : bus.CondE;
    ok  = (bus.ItStartE || ref_pass(eff, ref_flags())) && !bus.FlushE;
    return {ok && bus.BranchE, ok && bus.RegWriteE && !bus.NoWriteE, ok && bus.MemWriteE, ok};
  endfunction

  function automatic logic [8:0] ref_vec();
    return {ref_strobes(), 1'(m_cnt != 0), ref_flags()};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bus.PCSrcE, bus.RegWE, bus.MemWE, bus.CondExE, bus.ItActive, bus.FlagsE};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) m_flags[i] = 4'h0;
    m_cnt = 0;
    m_itc = 4'h0;
  endtask

  task automatic model_edge();
    logic [3:0] s;
    int len;
    s = ref_strobes();
    if (s[0] && !bus.StallE && int'(bus.FsetE) < NF) begin
      if (bus.FlagWE[1]) m_flags[bus.FsetE][3:2] = bus.AluFlags[3:2];
      if (bus.FlagWE[0]) m_flags[bus.FsetE][1:0] = bus.AluFlags[1:0];
    end
    if (!bus.FlushE && !bus.StallE) begin
      if (s[3]) m_cnt = 0;
      else if (bus.ItStartE) begin
        len   = int'(bus.ItLenE);
        m_cnt = (len > ITM) ? ITM : len;
        m_itc = bus.ItCondE;
      end else if (m_cnt > 0) m_cnt = m_cnt - 1;
    end
  endtask

  task automatic clear_inputs();
    bus.StallE = 0; bus.FlushE = 0; bus.CondE = 4'h0; bus.FsetE = '0;
    bus.FlagWE = 2'b00; bus.AluFlags = 4'h0; bus.BranchE = 0;
    bus.RegWriteE = 0; bus.MemWriteE = 0; bus.NoWriteE = 0;
    bus.ItStartE = 0; bus.ItCondE = 4'h0; bus.ItLenE = '0;
  endtask

  // Check outputs mid-cycle, then let the edge happen and advance the model.
  task automatic step(input string tag);
    @(negedge clk);
    check(tag, 32'(dut_vec()), 32'(ref_vec()));
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_vec()), 32'h0);
    rst = 1'b1;

    // CMP writing Z into set 0, then BEQ/BNE
    clear_inputs(); bus.CondE = 4'hE; bus.FlagWE = 2'b11; bus.AluFlags = 4'b0100;
    step("cmp");
    clear_inputs(); bus.BranchE = 1; bus.CondE = 4'h0;
    #1 check("beq_taken", 32'(bus.PCSrcE), 32'h1);
    check("flags_after_cmp", 32'(bus.FlagsE), 32'h4);
    step("beq");
    clear_inputs(); bus.BranchE = 1; bus.CondE = 4'h1;
    #1 check("bne_not_taken", 32'(bus.PCSrcE), 32'h0);
    step("bne");

    // Half-width flag write
    clear_inputs(); bus.CondE = 4'hE; bus.FlagWE = 2'b11; bus.AluFlags = 4'b0011;
    step("set_0011");
    clear_inputs(); bus.CondE = 4'hE; bus.FlagWE = 2'b10; bus.AluFlags = 4'b1011;
    step("nz_only");
    clear_inputs();
    #1 check("nz_half_write", 32'(bus.FlagsE), 32'hB);
    bus.FsetE = 2'd1;
    #1 check("set1_untouched", 32'(bus.FlagsE), 32'h0);
    step("read_set1");

    // Never-executing CMP and store
    clear_inputs(); bus.CondE = 4'hF; bus.FlagWE = 2'b11; bus.AluFlags = 4'h0; bus.MemWriteE = 1;
    #1 check("nv_store", 32'(bus.MemWE), 32'h0);
    step("nv_cmp");
    clear_inputs();
    #1 check("nv_cmp_no_flags", 32'(bus.FlagsE), 32'hB);

    // Window NE x3 with Z=0
    bus.ItStartE = 1; bus.ItCondE = 4'h1; bus.ItLenE = 3'd3; bus.CondE = 4'hF;
    step("it_start");
    for (int k = 0; k < 3; k++) begin
      clear_inputs(); bus.CondE = 4'hF; bus.RegWriteE = 1;
      #1 check("it_regwe", 32'(bus.RegWE), 32'h1);
      check("it_active", 32'(bus.ItActive), 32'h1);
      step("it_body");
    end
    clear_inputs();
    #1 check("it_closed", 32'(bus.ItActive), 32'h0);

    // Stall and flush hold the counter
    bus.ItStartE = 1; bus.ItCondE = 4'h1; bus.ItLenE = 3'd3;
    step("it_start2");
    clear_inputs(); bus.CondE = 4'hF;
    step("it_first");
    clear_inputs(); bus.CondE = 4'hF; bus.StallE = 1; bus.RegWriteE = 1;
    #1 check("stall_regwe", 32'(bus.RegWE), 32'h1);
    step("stall");
    clear_inputs(); bus.FlushE = 1; bus.BranchE = 1; bus.RegWriteE = 1; bus.MemWriteE = 1; bus.CondE = 4'hE;
    #1 check("flush_strobes", 32'({bus.PCSrcE, bus.RegWE, bus.MemWE, bus.CondExE}), 32'h0);
    step("flush");
    for (int k = 0; k < 2; k++) begin
      clear_inputs(); bus.CondE = 4'hF; bus.RegWriteE = 1;
      #1 check("held_window", 32'(bus.RegWE), 32'h1);
      step("held_body");
    end
    clear_inputs(); bus.CondE = 4'hF; bus.RegWriteE = 1;
    #1 check("after_held", 32'(bus.RegWE), 32'h0);
    step("after_held");

    // Taken branch kills the window
    clear_inputs(); bus.ItStartE = 1; bus.ItCondE = 4'h1; bus.ItLenE = 3'd4;
    step("it_start3");
    clear_inputs(); bus.BranchE = 1; bus.CondE = 4'hF;
    #1 check("branch_in_window", 32'(bus.PCSrcE), 32'h1);
    step("kill");
    clear_inputs(); bus.CondE = 4'hF; bus.RegWriteE = 1;
    #1 check("killed_own_cond", 32'(bus.RegWE), 32'h0);
    check("killed_inactive", 32'(bus.ItActive), 32'h0);
    step("post_kill");

    // Length clamp to IT_MAX
    clear_inputs(); bus.ItStartE = 1; bus.ItCondE = 4'hE; bus.ItLenE = 3'd7;
    step("it_start7");
    for (int k = 0; k < 5; k++) begin
      clear_inputs(); bus.CondE = 4'hF; bus.RegWriteE = 1;
      #1 check("clamp_regwe", 32'(bus.RegWE), (k < ITM) ? 32'h1 : 32'h0);
      step("clamp_body");
    end

    // Asynchronous reset mid-window
    clear_inputs(); bus.ItStartE = 1; bus.ItCondE = 4'h1; bus.ItLenE = 3'd3;
    step("it_start4");
    clear_inputs();
    #2 rst = 1'b0;
    #1 check("async_rst_active", 32'(bus.ItActive), 32'h0);
    check("async_rst_flags", 32'(bus.FlagsE), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;

    // Random instruction stream
    for (int t = 0; t < 400; t++) begin
      bus.StallE    = ($urandom_range(0, 5) == 0);
      bus.FlushE    = ($urandom_range(0, 5) == 0);
      bus.CondE     = 4'($urandom_range(0, 15));
      bus.FsetE     = 2'($urandom_range(0, 3));
      bus.FlagWE    = 2'($urandom_range(0, 3));
      bus.AluFlags  = 4'($urandom_range(0, 15));
      bus.BranchE   = ($urandom_range(0, 3) == 0);
      bus.RegWriteE = 1'($urandom_range(0, 1));
      bus.MemWriteE = 1'($urandom_range(0, 1));
      bus.NoWriteE  = ($urandom_range(0, 3) == 0);
      bus.ItStartE  = ($urandom_range(0, 6) == 0);
      bus.ItCondE   = 4'($urandom_range(0, 15));
      bus.ItLenE    = 3'($urandom_range(0, 7));
      step("random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
